// File: rtl/serial_sub_pkg.sv
// Shared types and elaboration helpers for the digit-serial subtractor.
package serial_sub_pkg;

  // Control FSM states
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Number of clock steps needed to walk WIDTH bits in DIGIT-bit slices
  function automatic int unsigned calc_steps(input int unsigned width,
                                             input int unsigned digit);
    return (digit == 0) ? 1 : width / digit;
  endfunction

  // Step-counter width, never narrower than one bit
  function automatic int unsigned calc_cnt_w(input int unsigned steps);
    return (steps <= 2) ? 1 : $clog2(steps);
  endfunction

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell: two half-subtract stages plus an OR.
module full_sub (
  input  logic a_in,
  input  logic b_in,
  input  logic borrow_in,
  output logic d_out,
  output logic b_out
);

  logic d_half;
  logic b_half;
  logic b_second;

  // First half-subtract (a - b), then subtract the incoming borrow
  always_comb begin
    d_half   = a_in ^ b_in;
    b_half   = ~a_in & b_in;
    d_out    = d_half ^ borrow_in;
    b_second = ~d_half & borrow_in;
    b_out    = b_half | b_second;
  end

endmodule

// File: rtl/serial_sub.sv
// Multi-cycle subtractor: a - b - borrow_in over WIDTH bits, DIGIT bits per clock.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] d_out,
  output logic             b_out,
  output logic             zero_out
);

  localparam int unsigned STEPS = calc_steps(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(STEPS);

  // Reject parameter sets that cannot be split into whole digits
  if (DIGIT < 1) begin : g_bad_digit
    $error("serial_sub: DIGIT must be at least 1");
  end else if (WIDTH % DIGIT != 0) begin : g_bad_width
    $error("serial_sub: WIDTH must be a multiple of DIGIT");
  end

  state_e             state;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic               borrow_q;
  logic [CNT_W-1:0]   cnt;
  logic [DIGIT:0]     chain;
  logic [DIGIT-1:0]   diff;
  logic [WIDTH-1:0]   result_c;
  logic               last_step;

  assign chain[0]  = borrow_q;
  assign last_step = (cnt == CNT_W'(STEPS - 1));

  // Ripple chain of DIGIT cells over the current low digit
  for (genvar i = 0; i < int'(DIGIT); i++) begin : g_cell
    full_sub u_cell (
      .a_in      (a_sr[i]),
      .b_in      (b_sr[i]),
      .borrow_in (chain[i]),
      .d_out     (diff[i]),
      .b_out     (chain[i+1])
    );
  end

  // Working result: earlier digits collect from the MSB side; the newest digit
  // completes the word, so only WIDTH-DIGIT bits need storing
  if (DIGIT == WIDTH) begin : g_one_step
    assign result_c = diff;
  end else begin : g_multi_step
    logic [WIDTH-DIGIT-1:0] work;

    assign result_c = {diff, work};

    // Shift each new difference digit in from the top
    always_ff @(posedge clk_in) begin
      if (rst_in) begin
        work <= '0;
      end else if (state == RUN) begin
        work <= result_c[WIDTH-1:DIGIT];
      end
    end
  end

  // Control FSM with operand shift registers, borrow, counter and result
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      busy_out <= 1'b0;
      done_out <= 1'b0;
      d_out    <= '0;
      b_out    <= 1'b0;
      zero_out <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            a_sr     <= a_in;
            b_sr     <= b_in;
            borrow_q <= borrow_in;
            cnt      <= '0;
            busy_out <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> DIGIT;
          b_sr     <= b_sr >> DIGIT;
          borrow_q <= chain[DIGIT];
          cnt      <= cnt + CNT_W'(1);
          if (last_step) begin
            d_out    <= result_c;
            b_out    <= chain[DIGIT];
            zero_out <= (result_c == '0) && !chain[DIGIT];
            done_out <= 1'b1;
            busy_out <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: three parameter sets driven in parallel.
module tb_serial_sub;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        borrow_in;

  wire  [2:0]  busy;
  wire  [2:0]  done;
  wire  [2:0]  bo;
  wire  [2:0]  z;
  wire  [7:0]  d0;
  wire  [7:0]  d1;
  wire  [15:0] d2;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8), .DIGIT(1)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .borrow_in(borrow_in),
    .busy_out(busy[0]), .done_out(done[0]), .d_out(d0), .b_out(bo[0]), .zero_out(z[0])
  );

  serial_sub #(.WIDTH(8), .DIGIT(4)) u_dut1 (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .a_in(a_in[7:0]), .b_in(b_in[7:0]), .borrow_in(borrow_in),
    .busy_out(busy[1]), .done_out(done[1]), .d_out(d1), .b_out(bo[1]), .zero_out(z[1])
  );

  serial_sub #(.WIDTH(16), .DIGIT(16)) u_dut2 (
    .clk_in(clk), .rst_in(rst), .start_in(start),
    .a_in(a_in), .b_in(b_in), .borrow_in(borrow_in),
    .busy_out(busy[2]), .done_out(done[2]), .d_out(d2), .b_out(bo[2]), .zero_out(z[2])
  );

  // Single comparison point: count, and report any disagreement
  task automatic check(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned wid(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int unsigned steps(input int i);
    return (i == 0) ? 8 : (i == 1) ? 2 : 1;
  endfunction

  function automatic logic [15:0] d_of(input int i);
    case (i)
      0:       return {8'h00, d0};
      1:       return {8'h00, d1};
      default: return d2;
    endcase
  endfunction

  // Plain-arithmetic reference: modular difference and borrow-out
  function automatic void ref_sub(input int unsigned w, input longint unsigned a,
                                  input longint unsigned b, input bit bi,
                                  output longint unsigned d, output bit bout, output bit zr);
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    a    = a & mask;
    b    = b & mask;
    bout = (a < b + longint'(bi));
    d    = (a - b - longint'(bi)) & mask;
    zr   = (d == 0) && !bout;
  endfunction

  // One operation on all three instances; checks latency, busy, hold and result
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int              lat[3];
    int              bc[3];
    bit              ov[3];
    bit              hb[3];
    bit              extra[3];
    logic [15:0]     prev[3];
    longint unsigned ed;
    bit              eb;
    bit              ez;
    @(negedge clk);
    a_in = a; b_in = b; borrow_in = bi; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lat[i] = 0; bc[i] = 0; ov[i] = 0; hb[i] = 0; extra[i] = 0; prev[i] = d_of(i);
    end
    for (int e = 1; e <= 11; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (busy[i] && done[i]) ov[i] = 1;
        if (done[i]) begin
          if (lat[i] == 0) begin
            lat[i]  = e;
            prev[i] = d_of(i);
          end else begin
            extra[i] = 1;
          end
        end else begin
          if (lat[i] == 0 && busy[i]) bc[i]++;
          if (d_of(i) != prev[i]) hb[i] = 1;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      ref_sub(wid(i), longint'(a), longint'(b), bi, ed, eb, ez);
      check($sformatf("latency_i%0d", i), longint'(lat[i]), longint'(steps(i) + 1));
      check($sformatf("busy_len_i%0d", i), longint'(bc[i]), longint'(steps(i)));
      check($sformatf("busy_done_overlap_i%0d", i), longint'(ov[i]), 0);
      check($sformatf("done_once_i%0d", i), longint'(extra[i]), 0);
      check($sformatf("result_hold_i%0d", i), longint'(hb[i]), 0);
      check($sformatf("d_i%0d", i), longint'(d_of(i)), ed);
      check($sformatf("b_i%0d", i), longint'(bo[i]), longint'(eb));
      check($sformatf("zero_i%0d", i), longint'(z[i]), longint'(ez));
    end
  endtask

  // start_in pulsed mid-operation must be ignored by the 8x1 instance
  task automatic start_while_busy();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a_in = 16'h005A; b_in = 16'h003C; borrow_in = 1'b0; start = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      start = (e == 3);
      if (e == 3) begin
        a_in = 16'h00FF; b_in = 16'h0000;
      end
      if (done[0]) ndone++;
    end
    check("busy_start_done_count", longint'(ndone), 1);
    check("busy_start_d", longint'(d0), 64'h1E);
    check("busy_start_b", longint'(bo[0]), 0);
  endtask

  // Reset after step 4 aborts the operation; reset also beats a coincident start
  task automatic reset_mid_op();
    int ndone;
    ndone = 0;
    @(negedge clk);
    a_in = 16'h005A; b_in = 16'h003C; borrow_in = 1'b0; start = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (e == 4) begin
        rst = 1'b1; start = 1'b1; a_in = 16'h0080; b_in = 16'h0001;
      end
      if (e == 5) begin
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
          check($sformatf("midrst_busy_i%0d", i), longint'(busy[i]), 0);
          check($sformatf("midrst_done_i%0d", i), longint'(done[i]), 0);
          check($sformatf("midrst_d_i%0d", i), longint'(d_of(i)), 0);
          check($sformatf("midrst_b_i%0d", i), longint'(bo[i]), 0);
          check($sformatf("midrst_zero_i%0d", i), longint'(z[i]), 0);
        end
      end
      if (e > 4 && done[0]) ndone++;
    end
    check("midrst_no_done", longint'(ndone), 0);
  endtask

  // start_in held high: one result every STEPS+1 clocks, held between dones
  task automatic back_to_back();
    logic [7:0]      opa[3];
    logic [7:0]      opb[3];
    logic            opc[3];
    int              idx;
    bit              hb;
    logic [15:0]     prev;
    longint unsigned ed;
    bit              eb;
    bit              ez;
    opa[0] = 8'h5A; opb[0] = 8'h3C; opc[0] = 1'b0;
    opa[1] = 8'h00; opb[1] = 8'h01; opc[1] = 1'b0;
    opa[2] = 8'h10; opb[2] = 8'h0F; opc[2] = 1'b1;
    idx = 0; hb = 0;
    @(negedge clk);
    a_in = {8'h00, opa[0]}; b_in = {8'h00, opb[0]}; borrow_in = opc[0]; start = 1'b1;
    prev = d_of(0);
    for (int e = 1; e <= 40 && idx < 3; e++) begin
      @(posedge clk); #1;
      if (done[0]) begin
        ref_sub(8, longint'(opa[idx]), longint'(opb[idx]), opc[idx], ed, eb, ez);
        check($sformatf("b2b_d%0d", idx), longint'(d0), ed);
        check($sformatf("b2b_b%0d", idx), longint'(bo[0]), longint'(eb));
        check($sformatf("b2b_time%0d", idx), longint'(e), longint'(9 * (idx + 1)));
        prev = d_of(0);
        idx++;
        if (idx < 3) begin
          a_in = {8'h00, opa[idx]}; b_in = {8'h00, opb[idx]}; borrow_in = opc[idx];
        end else begin
          start = 1'b0;
        end
      end else if (d_of(0) != prev) begin
        hb = 1;
      end
    end
    start = 1'b0;
    check("b2b_count", longint'(idx), 3);
    check("b2b_hold", longint'(hb), 0);
    repeat (12) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; borrow_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_busy_i%0d", i), longint'(busy[i]), 0);
      check($sformatf("rst_done_i%0d", i), longint'(done[i]), 0);
      check($sformatf("rst_d_i%0d", i), longint'(d_of(i)), 0);
      check($sformatf("rst_b_i%0d", i), longint'(bo[i]), 0);
      check($sformatf("rst_zero_i%0d", i), longint'(z[i]), 0);
    end
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h005A, 16'h003C, 1'b0);
    check("basic_d", longint'(d0), 64'h1E);
    check("basic_b", longint'(bo[0]), 0);
    check("basic_zero", longint'(z[0]), 0);

    run_op(16'h0000, 16'h0001, 1'b0);
    check("uf1_d", longint'(d0), 64'hFF);
    check("uf1_b", longint'(bo[0]), 1);
    run_op(16'h0010, 16'h0010, 1'b1);
    check("uf2_d", longint'(d0), 64'hFF);
    check("uf2_b", longint'(bo[0]), 1);
    run_op(16'h0010, 16'h000F, 1'b1);
    check("uf3_d", longint'(d0), 64'h00);
    check("uf3_zero", longint'(z[0]), 1);

    run_op(16'h00A3, 16'h005C, 1'b0);
    check("digit4_d", longint'(d1), 64'h47);
    run_op(16'h0000, 16'hFFFF, 1'b0);
    check("full16_d", longint'(d2), 64'h0001);
    check("full16_b", longint'(bo[2]), 1);

    start_while_busy();
    reset_mid_op();
    run_op(16'h0080, 16'h0001, 1'b0);
    check("after_rst_d", longint'(d0), 64'h7F);

    back_to_back();

    for (int n = 0; n < 25; n++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
# serial_sub

Parametrised multi-cycle subtractor: computes `a_in - b_in - borrow_in` over `WIDTH` bits, `DIGIT` bits per clock, using a chain of full-subtractor cells and a registered borrow. It is the sequential successor of the single-bit subtract cells. Intended for datapaths where a wide single-cycle subtract is too costly, such as counters, comparators and ALU slices. It uses a start/busy/done handshake and holds its result until the next operation completes.

## Interface
- `WIDTH`, 8, operand and result width; must be a multiple of `DIGIT`.
- `DIGIT`, 1, bits processed per clock; `DIGIT == WIDTH` gives a one-step operation.
- `clk_in`  in  1  single clock; all logic on the rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `start_in`  in  1  request; accepted only on an edge where the block is IDLE.
- `a_in`  in  WIDTH  minuend (unsigned), sampled on the accept edge.
- `b_in`  in  WIDTH  subtrahend (unsigned), sampled on the accept edge.
- `borrow_in`  in  1  initial borrow, sampled on the accept edge.
- `busy_out`  out  1  high while an operation is in progress.
- `done_out`  out  1  one-cycle pulse; the result is valid from this cycle on.
- `d_out`  out  WIDTH  difference, `(a - b - borrow_in) mod 2^WIDTH`.
- `b_out`  out  1  final borrow; 1 iff `a < b + borrow_in`.
- `zero_out`  out  1  1 iff `d_out == 0` and `b_out == 0` (operands equal after borrow).

## Operation
- `STEPS = WIDTH/DIGIT`. FSM states: IDLE and RUN.
- **IDLE, start_in=1:** on the edge, load the A/B shift registers and the borrow register (from `borrow_in`), clear the step counter, go to RUN.
- **RUN:** each edge processes the `DIGIT` LSBs of A/B with the current borrow through the cell chain.
  - Shift the diff digits into the working result from the MSB side.
  - Shift A/B right by `DIGIT`; store the chain borrow; increment the counter.
- **RUN, last step (counter == STEPS-1):**
  - copy the working result to `d_out`;
  - copy the final borrow to `b_out`;
  - update `zero_out`;
  - pulse `done_out`;
  - return to IDLE.
- `start_in` while in RUN is ignored: not queued, no effect on the operation in progress.
- `done_out` is asserted in an IDLE cycle, so `start_in` in that cycle is accepted (back-to-back operations).
- `d_out`, `b_out` and `zero_out` hold the previous result throughout the next operation. They change only on that operation's done edge.
- `rst_in` (any state, including mid-RUN):
  - next state IDLE; the operation is aborted and no `done_out` is produced;
  - all outputs 0, all internal registers 0.
- If `rst_in` and `start_in` are asserted together, reset wins.
- Arithmetic is unsigned modulo 2^WIDTH. The borrow chain is never truncated between steps.
- Elaboration error if `WIDTH % DIGIT != 0` or `DIGIT < 1`.

## Timing
- **Reset values:** `busy_out=0`, `done_out=0`, `d_out=0`, `b_out=0`, `zero_out=0`.
- **Accept edge E0:** `busy_out` is 1 from the cycle after E0.
- **Step edges:** E1..E_STEPS process the digits.
- **Done edge E_STEPS:** `busy_out` falls, and `done_out`/results are visible in the cycle after E_STEPS.
- **Latency:** STEPS+1 clocks from the start cycle to the `done_out` cycle.
- **Throughput:** one operation per STEPS+1 clocks with back-to-back starts.
- `done_out` is exactly one cycle wide.
- `busy_out` and `done_out` are never high together.
- Critical path: `DIGIT` cascaded cells plus the borrow register.

## Structure
- **Shared package:** the FSM state enum (IDLE, RUN) and the derived `STEPS` and counter width (`$clog2(STEPS)`, minimum 1) helpers.
- **Sub-module `full_sub`:** one full-subtractor cell (`a_in`, `b_in`, `borrow_in` → `d_out`, `b_out`), built as two half-subtract stages plus an OR. It is instantiated `DIGIT` times in a generate chain.
- **Top level:** FSM, step counter, operand shift registers, working and result registers.

## Test plan
- **Basic subtract:** WIDTH=8, DIGIT=1, start with a=0x5A, b=0x3C, borrow_in=0 → `done_out` 9 clocks after the start cycle, `d_out=0x1E`, `b_out=0`, `zero_out=0`; `busy_out` high for exactly 8 cycles.
- **Underflow:** a=0x00, b=0x01 → `d_out=0xFF`, `b_out=1`. Then a=0x10, b=0x10, borrow_in=1 → `d_out=0xFF`, `b_out=1`. Then a=0x10, b=0x0F, borrow_in=1 → `d_out=0x00`, `b_out=0`, `zero_out=1`.
- **Wider digit:** WIDTH=8, DIGIT=4, a=0xA3, b=0x5C → done 3 clocks after start, `d_out=0x47`. Also WIDTH=16, DIGIT=16, a=0x0000, b=0xFFFF → done after 2 clocks, `d_out=0x0001`, `b_out=1`.
- **Start while busy:** second start (a=0xFF, b=0x00) pulsed at step 3 of a 0x5A−0x3C operation → ignored; result 0x1E; exactly one `done_out`.
- **Reset mid-operation:** `rst_in` at step 4 → next cycle all outputs 0, no `done_out`. A following start of 0x80−0x01 → 0x7F.
- **Back-to-back:** `start_in` held high over 3 operations → `done_out` every 9 clocks. Each result is held stable until the next done.
- **Random:** compare against a reference model for every operation.
